commit_sequencer: RTL
=====================

# commit_sequencer

Parametrised in-order commit stage between the instruction branches and the channel/accumulator register files. Each cycle it accepts at most one branch result whose `commit_id` matches `next_commit_id`. It registers that result for one cycle, then writes it to a channel register or to the accumulator. It also injects the incoming audio sample into channel 0 on `sample_tick`, and adds program-restart, conflict/destination error reporting and optional saturating narrowing.

## Interface
- `DATA_WIDTH`, 16, channel sample width; results are 2*DATA_WIDTH.
- `N_BLOCKS`, 256, block count; block index width is clog2(N_BLOCKS).
- `N_BRANCHES`, 4, number of instruction branches.
- `MAC_BRANCH`, 1, index of the branch that targets the accumulator.
- `N_CHANNELS`, 16, channel registers; CH_AW = clog2(N_CHANNELS).
- `ID_WIDTH`, 9, commit id width.

Ports:
- `clk`  in  1  clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  global run enable.
- `sample_tick`  in  1  new sample strobe.
- `sample_in`  in  DATA_WIDTH  signed sample written to channel 0.
- `id_clear`  in  1  synchronous program restart; sets next_commit_id to 0.
- `in_valid`  in  N_BRANCHES  per-branch result valid.
- `in_ready`  out  N_BRANCHES  per-branch accept (combinational).
- `block_in[N_BRANCHES]`  in  clog2(N_BLOCKS)  originating block index.
- `result[N_BRANCHES]`  in  2*DATA_WIDTH  signed result.
- `dest[N_BRANCHES]`  in  CH_AW  destination channel.
- `commit_id[N_BRANCHES]`  in  ID_WIDTH  result sequence number.
- `commit_flag`  in  N_BRANCHES  MAC branch only: 1 = overwrite accumulator, 0 = add.
- `channel_write_addr`  out  CH_AW;  `channel_write_val`  out  DATA_WIDTH;  `channel_write_enable`  out  1.
- `accumulator_write_val`  out  2*DATA_WIDTH;  `accumulator_write_enable`  out  1;  `accumulator_add_enable`  out  1.
- `next_commit_id`  out  ID_WIDTH  id expected next.
- `last_block`  out  clog2(N_BLOCKS)  block index of the most recent write.
- `commit_conflict`  out  1  sticky; more than one branch matched in a single cycle.
- `dest_error`  out  1  sticky; dest >= N_CHANNELS was dropped.
- `sat_event`  out  1  pulse; the current channel write was clipped.

## Operation
- Match: `m[i] = in_valid[i] & (commit_id[i] == next_commit_id)`.
- Grant: the lowest-index set bit of `m`.
- `in_ready` = one-hot grant, gated by `enable & ~sample_tick & ~id_clear & reset_n`.
- If more than one `m` bit is set while accepting, set `commit_conflict`. Only the granted branch is consumed.
- On accept:
  - next_commit_id increments, wrapping modulo 2^ID_WIDTH.
  - The hold register captures {valid, branch, result, dest, commit_flag, block_in}.
- Drain (cycle after accept):
  - MAC_BRANCH: `accumulator_write_val` = result, `accumulator_write_enable` = 1, `accumulator_add_enable` = ~flag.
  - Other branches: `channel_write_addr` = dest and `channel_write_val` = narrow(result), with enable = 1. If dest >= N_CHANNELS, the enable stays 0 and `dest_error` is set.
  - `last_block` updates on every drain.
- Accept and drain happen in the same cycle. Throughput is one commit per cycle.
- sample_tick with enable:
  - channel 0 is written with sample_in.
  - The hold register is retained and drains in the first cycle with sample_tick low.
  - No accept occurs during sample_tick.
- enable low: no accept, no drain, hold register retained, all write enables 0.
- id_clear: next_commit_id = 0 on the next edge.
  - The hold register still drains.
  - If id_clear and sample_tick coincide, both actions occur.
- Sticky flags clear only on reset.

## Timing
- All outputs are registered except `in_ready`.
- Write enables and `sat_event` are single-cycle pulses.
- Latency from accept edge to write strobe is 1 cycle.
- Results are committed strictly in id order. Out-of-order arrivals wait with in_valid held high.
- Asynchronous reset (reset_n low) sets all registered outputs to 0, clears the hold register, sets next_commit_id to 0 and clears the sticky flags.
- A reset asserted mid-drain discards the pending write.
- Channel writes from the hold register and the sample write never coincide, because drain is suppressed during a tick.

## Configuration
- `COMMIT_SAT_EN` defined: narrow() clips the signed 2*DATA_WIDTH result to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]. `sat_event` pulses alongside any clipped channel write.
- `COMMIT_SAT_EN` undefined: narrow() takes the low DATA_WIDTH bits. `sat_event` is tied to 0.

## Test plan
- **Ordered commit:** branch 0 is valid with id 0, result 0x0000_1234, dest 3 → in_ready[0] in cycle 0; next cycle ch3 = 0x1234 with enable pulse; next_commit_id = 1.
- **Out-of-order and MAC:** branch 2 id 1 and MAC id 0 (flag 1, result 0x0001_0000) are valid together.
  - MAC is accepted first; the accumulator is overwritten (add_enable 0).
  - Branch 2 is accepted the following cycle.
  - The MAC repeats with flag 0 → add_enable 1.
- **Tick collision:** accept id 5, then sample_tick = 1 for 2 cycles with sample_in = 0x7FFF.
  - ch0 = 0x7FFF.
  - The id-5 write appears in the cycle after the tick drops.
  - in_ready stays 0 during the tick.
- **Conflict:** branches 0 and 3 are both valid with id 7 → branch 0 is granted, commit_conflict = 1, and branch 3 is not accepted until a later id 7 match.
- **Saturation:** result 0x0002_0000 to dest 1 → ch1 = 0x7FFF and sat_event = 1 with COMMIT_SAT_EN; ch1 = 0x0000 and sat_event = 0 without.
- **Reset and id_clear:**
  - Raise id_clear at id 42 → next_commit_id = 0 next cycle.
  - Pull reset_n low during a drain → write enables drop immediately, the write is lost and all outputs read 0.

Source files
------------

// File: rtl/commit_sequencer.sv
// In-order commit stage: one matching branch result per cycle into a one-entry hold register,
// drained next cycle to a channel or the accumulator. Define COMMIT_SAT_EN for saturating narrowing.
module commit_sequencer #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned N_BLOCKS   = 256,
  parameter int unsigned N_BRANCHES = 4,
  parameter int unsigned MAC_BRANCH = 1,
  parameter int unsigned N_CHANNELS = 16,
  parameter int unsigned ID_WIDTH   = 9,
  localparam int unsigned BLK_W = $clog2(N_BLOCKS),
  localparam int unsigned CH_AW = $clog2(N_CHANNELS),
  localparam int unsigned RES_W = 2 * DATA_WIDTH,
  localparam int unsigned BR_W  = (N_BRANCHES > 1) ? $clog2(N_BRANCHES) : 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  sample_tick,
  input  logic [DATA_WIDTH-1:0] sample_in,
  input  logic                  id_clear,
  input  logic [N_BRANCHES-1:0] in_valid,
  output logic [N_BRANCHES-1:0] in_ready,
  input  logic [BLK_W-1:0]      block_in [N_BRANCHES],
  input  logic [RES_W-1:0]      result [N_BRANCHES],
  input  logic [CH_AW-1:0]      dest [N_BRANCHES],
  input  logic [ID_WIDTH-1:0]   commit_id [N_BRANCHES],
  input  logic [N_BRANCHES-1:0] commit_flag,
  output logic [CH_AW-1:0]      channel_write_addr,
  output logic [DATA_WIDTH-1:0] channel_write_val,
  output logic                  channel_write_enable,
  output logic [RES_W-1:0]      accumulator_write_val,
  output logic                  accumulator_write_enable,
  output logic                  accumulator_add_enable,
  output logic [ID_WIDTH-1:0]   next_commit_id,
  output logic [BLK_W-1:0]      last_block,
  output logic                  commit_conflict,
  output logic                  dest_error,
  output logic                  sat_event
);

  localparam logic [CH_AW:0] NCH = N_CHANNELS[CH_AW:0];
  localparam logic [BR_W-1:0] MAC_IDX = MAC_BRANCH[BR_W-1:0];

  logic                  hold_valid;
  logic [BR_W-1:0]       hold_branch;
  logic [RES_W-1:0]      hold_result;
  logic [CH_AW-1:0]      hold_dest;
  logic                  hold_flag;
  logic [BLK_W-1:0]      hold_block;

  logic [N_BRANCHES-1:0] match;
  logic [N_BRANCHES-1:0] grant;
  logic [BR_W-1:0]       grant_idx;
  logic                  found;
  logic                  multi;
  logic                  accept_ok;
  logic                  accept;
  logic                  drain;
  logic                  dest_bad;
  logic [DATA_WIDTH-1:0] narrowed;
  logic                  clipped;

  always_comb begin
    match     = '0;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int unsigned i = 0; i < N_BRANCHES; i++) begin
      match[i] = in_valid[i] && (commit_id[i] == next_commit_id);
    end
    for (int unsigned i = 0; i < N_BRANCHES; i++) begin
      if (match[i] && !found) begin
        grant[i]  = 1'b1;
        grant_idx = BR_W'(i);
        found     = 1'b1;
      end
    end
    // More than one bit set iff clearing the lowest set bit leaves something behind.
    multi     = (match & (match - 1'b1)) != '0;
    accept_ok = enable && !sample_tick && !id_clear && reset_n;
    in_ready  = accept_ok ? grant : '0;
    accept    = accept_ok && found;
    drain     = enable && !sample_tick && hold_valid;
    dest_bad  = {1'b0, hold_dest} >= NCH;
  end

`ifdef COMMIT_SAT_EN
  logic [RES_W-DATA_WIDTH:0] upper;
  always_comb begin
    upper    = hold_result[RES_W-1:DATA_WIDTH-1];
    clipped  = (upper != '0) && (upper != '1);
    narrowed = hold_result[DATA_WIDTH-1:0];
    if (clipped) begin
      narrowed = hold_result[RES_W-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                      : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end
  end
`else
  always_comb begin
    narrowed = hold_result[DATA_WIDTH-1:0];
    clipped  = 1'b0;
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_valid               <= 1'b0;
      hold_branch              <= '0;
      hold_result              <= '0;
      hold_dest                <= '0;
      hold_flag                <= 1'b0;
      hold_block               <= '0;
      channel_write_addr       <= '0;
      channel_write_val        <= '0;
      channel_write_enable     <= 1'b0;
      accumulator_write_val    <= '0;
      accumulator_write_enable <= 1'b0;
      accumulator_add_enable   <= 1'b0;
      next_commit_id           <= '0;
      last_block               <= '0;
      commit_conflict          <= 1'b0;
      dest_error               <= 1'b0;
      sat_event                <= 1'b0;
    end else begin
      channel_write_enable     <= 1'b0;
      accumulator_write_enable <= 1'b0;
      accumulator_add_enable   <= 1'b0;
      sat_event                <= 1'b0;

      if (id_clear) begin
        next_commit_id <= '0;
      end else if (accept) begin
        next_commit_id <= next_commit_id + 1'b1;
      end
      if (accept && multi) begin
        commit_conflict <= 1'b1;
      end

      // The sample write owns the channel port for the whole tick; drain waits.
      if (enable && sample_tick) begin
        channel_write_addr   <= '0;
        channel_write_val    <= sample_in;
        channel_write_enable <= 1'b1;
      end else if (drain) begin
        last_block <= hold_block;
        if (hold_branch == MAC_IDX) begin
          accumulator_write_val    <= hold_result;
          accumulator_write_enable <= 1'b1;
          accumulator_add_enable   <= !hold_flag;
        end else if (dest_bad) begin
          dest_error <= 1'b1;
        end else begin
          channel_write_addr   <= hold_dest;
          channel_write_val    <= narrowed;
          channel_write_enable <= 1'b1;
          sat_event            <= clipped;
        end
      end

      if (accept) begin
        hold_valid  <= 1'b1;
        hold_branch <= grant_idx;
        hold_result <= result[grant_idx];
        hold_dest   <= dest[grant_idx];
        hold_flag   <= commit_flag[grant_idx];
        hold_block  <= block_in[grant_idx];
      end else if (drain) begin
        hold_valid <= 1'b0;
      end
    end
  end

endmodule
